// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared constants, FSM encoding and store helpers for dmem_ctrl
// Contents: Funct3 size/sign codes, size-field codes, FSM state type,
//           store byte-enable / lane-replication helpers, alignment test.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Funct3[1:0] alone carries the access size for both loads and stores.
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10,
    ST_DONE = 2'b11
  } state_t;

  function automatic logic [3:0] store_be(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      SZ_B:    return 4'b0001 << off;
      SZ_H:    return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Replicate the store operand onto every lane so the byte enables alone
  // select which bytes land in memory.
  function automatic logic [31:0] store_data(input logic [1:0] sz, input logic [31:0] d);
    case (sz)
      SZ_B:    return {4{d[7:0]}};
      SZ_H:    return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      SZ_H:    return off[0];
      SZ_W:    return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - combinational load formatter (byte/half select, sign/zero extend)
// Ports: rdata  - raw 32-bit word from the bus
//        off    - byte offset Addr[1:0] of the access
//        funct3 - access size/sign code
//        result - formatted 32-bit load value
module load_align
  import dmem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b      = rdata[7:0];
    h      = rdata[15:0];
    result = rdata;
    case (off)
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    // Halfword lane comes from Addr[1] only; Addr[0] never splits a half.
    h = off[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_B:    result = {{24{b[7]}}, b};
      F3_H:    result = {{16{h[15]}}, h};
      F3_BU:   result = {24'h000000, b};
      F3_HU:   result = {16'h0000, h};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - data-memory access controller between datapath and a gnt/rvalid bus
// Parameter: TIMEOUT - max cycles in REQ+WAIT before the access is aborted.
// Macro:     DMEM_MISALIGN_TRAP_EN - trap misaligned H/W accesses without a bus request.
// Ports: clk, reset (async, active high)
//        MemRead/MemWrite/Funct3/Addr/StoreData - request from the datapath
//        ReadData/Stall/BusErr/MisalignErr      - results to the datapath
//        mem_req/mem_we/mem_addr/mem_wdata/mem_be - bus request side
//        mem_gnt/mem_rvalid/mem_rdata           - bus response side
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  Funct3,
  input  logic [31:0] Addr,
  input  logic [31:0] StoreData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        BusErr,
  output logic        MisalignErr,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  // The counter only has to reach TIMEOUT-1 (the last permitted cycle).
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [1:0]    off_q;
  logic [2:0]    f3_q;
  logic          load_q;
  logic [31:0]   fmt;
  logic          req_in;
  logic          last_cycle;

  assign req_in     = MemRead | MemWrite;
  assign last_cycle = (cnt == CNT_LAST);

  // Offset and size are latched at IDLE exit so formatting does not depend
  // on the datapath keeping Addr/Funct3 stable through the wait.
  load_align u_load_align (
    .rdata  (mem_rdata),
    .off    (off_q),
    .funct3 (f3_q),
    .result (fmt)
  );

  // IDLE term is combinational so the PC freezes in the request cycle itself.
  assign Stall = ((state == ST_IDLE) && req_in) || (state == ST_REQ) || (state == ST_WAIT);

`ifdef DMEM_MISALIGN_TRAP_EN
  logic mis_q;
  logic mis_now;
  assign mis_now     = misaligned(Funct3[1:0], Addr[1:0]);
  assign MisalignErr = mis_q;
`else
  assign MisalignErr = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      off_q     <= 2'b00;
      f3_q      <= 3'b000;
      load_q    <= 1'b0;
      ReadData  <= 32'h0;
      BusErr    <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= 4'b0000;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
`ifdef DMEM_MISALIGN_TRAP_EN
      mis_q     <= 1'b0;
`endif
    end else begin
      BusErr <= 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
      mis_q  <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (req_in) begin
            cnt    <= '0;
            off_q  <= Addr[1:0];
            f3_q   <= Funct3;
            load_q <= ~MemWrite;
`ifdef DMEM_MISALIGN_TRAP_EN
            if (mis_now) begin
              state <= ST_DONE;
              mis_q <= 1'b1;
              if (!MemWrite) ReadData <= 32'h0;
            end else
`endif
            begin
              state     <= ST_REQ;
              mem_req   <= 1'b1;
              mem_we    <= MemWrite;
              mem_be    <= MemWrite ? store_be(Funct3[1:0], Addr[1:0]) : 4'b1111;
              mem_addr  <= {Addr[31:2], 2'b00};
              mem_wdata <= store_data(Funct3[1:0], StoreData);
            end
          end
        end

        ST_REQ: begin
          cnt <= cnt + 1'b1;
          if (mem_gnt) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            mem_be  <= 4'b0000;
            state   <= load_q ? ST_WAIT : ST_DONE;
          end else if (last_cycle) begin
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            mem_be   <= 4'b0000;
            ReadData <= 32'h0;
            BusErr   <= 1'b1;
            state    <= ST_DONE;
          end
        end

        ST_WAIT: begin
          cnt <= cnt + 1'b1;
          if (mem_rvalid) begin
            ReadData <= fmt;
            state    <= ST_DONE;
          end else if (last_cycle) begin
            ReadData <= 32'h0;
            BusErr   <= 1'b1;
            state    <= ST_DONE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb/tb_dmem_ctrl.sv - self-checking bench for dmem_ctrl
module tb_dmem_ctrl;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead, MemWrite;
  logic [2:0]  Funct3;
  logic [31:0] Addr, StoreData;
  logic [31:0] ReadData;
  logic        Stall, BusErr, MisalignErr;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  dmem_ctrl #(.TIMEOUT(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .Funct3      (Funct3),
    .Addr        (Addr),
    .StoreData   (StoreData),
    .ReadData    (ReadData),
    .Stall       (Stall),
    .BusErr      (BusErr),
    .MisalignErr (MisalignErr),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_be      (mem_be),
    .mem_gnt     (mem_gnt),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata)
  );

  int n_pass = 0;
  int n_tot  = 0;

  logic        chk_en = 1'b0;
  logic        e_stall, e_req, e_buserr, e_mis, e_we;
  logic [31:0] e_rd, e_addr, e_wdata;
  logic [3:0]  e_be;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall",    {31'd0, Stall},       {31'd0, e_stall});
      chk("mem_req",  {31'd0, mem_req},     {31'd0, e_req});
      chk("buserr",   {31'd0, BusErr},      {31'd0, e_buserr});
      chk("misalign", {31'd0, MisalignErr}, {31'd0, e_mis});
      chk("readdata", ReadData, e_rd);
      if (e_req) begin
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_we", {31'd0, mem_we}, {31'd0, e_we});
        if (e_we) begin
          chk("mem_be", {28'd0, mem_be}, {28'd0, e_be});
          chk("mem_wdata", mem_wdata, e_wdata);
        end
      end
    end
  end

  function automatic logic [31:0] model_load(input logic [31:0] rd, input logic [31:0] a, input logic [2:0] f3);
    logic [31:0] b, h;
    b = (rd >> (int'(a[1:0]) * 8)) & 32'hFF;
    h = (rd >> (int'(a[1]) * 16)) & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 32'd128) ? b - 32'd256 : b;
      3'b001:  return (h >= 32'd32768) ? h - 32'd65536 : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return rd;
    endcase
  endfunction

  function automatic logic model_mis(input logic [2:0] f3, input logic [31:0] a);
`ifdef DMEM_MISALIGN_TRAP_EN
    if ((f3 == 3'b001 || f3 == 3'b101) && a[0]) return 1'b1;
    if (f3 == 3'b010 && a[1:0] != 2'b00) return 1'b1;
`else
    if (f3 == 3'b111 && a == 32'hFFFF_FFFF) return 1'b1;
`endif
    return 1'b0;
  endfunction

  task automatic access(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] sd, input int gnt_at, input int rv_at,
                        input logic [31:0] rdat, output int stalls,
                        output logic [3:0] be_seen, output logic [31:0] wd_seen,
                        output logic [31:0] ad_seen);
    int   t;
    logic in_req, fin, tmo;
    stalls = 0; be_seen = 4'h0; wd_seen = 32'h0; ad_seen = 32'h0;
    @(posedge clk); #1;
    MemRead = ~wr; MemWrite = wr; Funct3 = f3; Addr = a; StoreData = sd;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = rdat;
    e_stall = 1'b1; e_req = 1'b0; e_buserr = 1'b0; e_mis = 1'b0;
    stalls = 1;
    if (model_mis(f3, a)) begin
      @(posedge clk); #1;
      e_stall = 1'b0; e_mis = 1'b1;
      if (!wr) e_rd = 32'h0;
    end else begin
      t = 0; in_req = 1'b1; fin = 1'b0; tmo = 1'b0;
      e_addr = a & 32'hFFFF_FFFC;
      e_we   = wr;
      case (f3[1:0])
        2'b00:   begin e_be = 4'b0001 << a[1:0]; e_wdata = (sd & 32'hFF) * 32'h0101_0101; end
        2'b01:   begin e_be = a[1] ? 4'b1100 : 4'b0011; e_wdata = (sd & 32'hFFFF) * 32'h0001_0001; end
        default: begin e_be = 4'b1111; e_wdata = sd; end
      endcase
      while (!fin) begin
        @(posedge clk); #1;
        mem_gnt    = in_req && (t == gnt_at);
        mem_rvalid = (t == rv_at);
        mem_rdata  = in_req ? ~rdat : rdat;
        e_stall = 1'b1; e_req = in_req;
        stalls++;
        if (t == 0) begin be_seen = mem_be; wd_seen = mem_wdata; ad_seen = mem_addr; end
        if (in_req && mem_gnt) begin
          if (wr) fin = 1'b1; else in_req = 1'b0;
        end else if (!in_req && mem_rvalid) begin
          fin = 1'b1;
        end else if (t == TO - 1) begin
          fin = 1'b1; tmo = 1'b1;
        end
        t++;
      end
      @(posedge clk); #1;
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      e_stall = 1'b0; e_req = 1'b0; e_buserr = tmo;
      if (tmo) e_rd = 32'h0;
      else if (!wr) e_rd = model_load(rdat, a, f3);
    end
    // Requests still held in DONE must be ignored; release them next cycle.
    @(posedge clk); #1;
    MemRead = 1'b0; MemWrite = 1'b0;
    e_stall = 1'b0; e_req = 1'b0; e_buserr = 1'b0; e_mis = 1'b0;
  endtask

  int          st;
  logic [3:0]  bs;
  logic [31:0] ws, as;

  initial begin
    reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; Funct3 = 3'b010;
    Addr = 32'h0; StoreData = 32'h0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    e_stall = 1'b0; e_req = 1'b0; e_buserr = 1'b0; e_mis = 1'b0; e_we = 1'b0;
    e_rd = 32'h0; e_addr = 32'h0; e_wdata = 32'h0; e_be = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall",    {31'd0, Stall},       32'd0);
    chk("rst_mem_req",  {31'd0, mem_req},     32'd0);
    chk("rst_mem_we",   {31'd0, mem_we},      32'd0);
    chk("rst_buserr",   {31'd0, BusErr},      32'd0);
    chk("rst_misalign", {31'd0, MisalignErr}, 32'd0);
    chk("rst_readdata", ReadData,             32'd0);
    chk("rst_mem_be",   {28'd0, mem_be},      32'd0);
    reset = 1'b0;
    chk_en = 1'b1;

    access(1'b0, 3'b010, 32'h100, 32'h0, 0, 1, 32'hDEADBEEF, st, bs, ws, as);
    chk("lw_stall_cycles", st, 3);
    chk("lw_readdata", ReadData, 32'hDEADBEEF);

    access(1'b0, 3'b000, 32'h103, 32'h0, 0, 1, 32'h80FF0000, st, bs, ws, as);
    chk("lb_readdata", ReadData, 32'hFFFFFF80);
    access(1'b0, 3'b100, 32'h103, 32'h0, 1, 3, 32'h80FF0000, st, bs, ws, as);
    chk("lbu_readdata", ReadData, 32'h00000080);

    access(1'b1, 3'b001, 32'h102, 32'h0000ABCD, 2, -1, 32'h0, st, bs, ws, as);
    chk("sh_be",    {28'd0, bs}, 32'hC);
    chk("sh_wdata", ws, 32'hABCDABCD);
    chk("sh_addr",  as, 32'h100);
    chk("sh_keeps_readdata", ReadData, 32'h00000080);

    access(1'b1, 3'b000, 32'h201, 32'h12345678, 0, -1, 32'h0, st, bs, ws, as);
    chk("sb_be",    {28'd0, bs}, 32'h2);
    chk("sb_wdata", ws, 32'h78787878);
    access(1'b1, 3'b010, 32'h204, 32'hCAFEBABE, 0, -1, 32'h0, st, bs, ws, as);
    access(1'b0, 3'b001, 32'h102, 32'h0, 0, 1, 32'h80017FFF, st, bs, ws, as);
    chk("lh_hi_readdata", ReadData, 32'hFFFF8001);
    access(1'b0, 3'b101, 32'h100, 32'h0, 0, 2, 32'h8001F00D, st, bs, ws, as);
    access(1'b0, 3'b001, 32'h100, 32'h0, 0, 1, 32'h8001F00D, st, bs, ws, as);

    // rvalid on the very last permitted cycle still completes.
    access(1'b0, 3'b010, 32'h300, 32'h0, 0, TO - 1, 32'h13579BDF, st, bs, ws, as);
    chk("late_rvalid_readdata", ReadData, 32'h13579BDF);
    // gnt withheld: abort from REQ.
    access(1'b0, 3'b010, 32'h100, 32'h0, 1000, 1000, 32'h11111111, st, bs, ws, as);
    chk("tmo_req_stall_cycles", st, TO + 1);
    chk("tmo_req_readdata", ReadData, 32'h0);
    access(1'b0, 3'b000, 32'h101, 32'h0, 0, 1, 32'h0000AA00, st, bs, ws, as);
    // rvalid during REQ is ignored, then never returns: abort from WAIT.
    access(1'b0, 3'b010, 32'h104, 32'h0, 3, 1, 32'h22222222, st, bs, ws, as);
    chk("tmo_wait_readdata", ReadData, 32'h0);
    access(1'b1, 3'b010, 32'h108, 32'h5A5A5A5A, 1000, -1, 32'h0, st, bs, ws, as);

    access(1'b0, 3'b010, 32'h102, 32'h0, 0, 1, 32'hCAFEF00D, st, bs, ws, as);
`ifdef DMEM_MISALIGN_TRAP_EN
    chk("mis_lw_readdata", ReadData, 32'h0);
    chk("mis_lw_stall_cycles", st, 1);
`else
    chk("mis_lw_addr", as, 32'h100);
    chk("mis_lw_readdata", ReadData, 32'hCAFEF00D);
`endif

    // Reset in WAIT, then a stray rvalid.
    @(posedge clk); #1;
    MemRead = 1'b1; Funct3 = 3'b010; Addr = 32'h300;
    e_stall = 1'b1; e_req = 1'b0;
    @(posedge clk); #1;
    mem_gnt = 1'b1; e_req = 1'b1; e_addr = 32'h300; e_we = 1'b0;
    @(posedge clk); #1;
    mem_gnt = 1'b0; reset = 1'b1; MemRead = 1'b0;
    e_stall = 1'b0; e_req = 1'b0; e_rd = 32'h0;
    @(posedge clk); #1;
    reset = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    chk("rst_wait_readdata", ReadData, 32'h0);
    chk("rst_wait_stall", {31'd0, Stall}, 32'd0);
    @(posedge clk); #1;
    chk_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 255, SHALL set the maximum cycles spent in REQ+WAIT before the access is aborted.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 MemRead  input  1  load request from the control path.
REQ-005 MemWrite  input  1  store request from the control path.
REQ-006 Funct3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 Addr  input  32  byte address, driven by the datapath ALUResult.
REQ-008 StoreData  input  32  store data, driven by register-file RD2.
REQ-009 ReadData  output  32  formatted load data to the datapath ResultMux.
REQ-010 Stall  output  1  freezes PC and register-file write while high.
REQ-011 BusErr  output  1  one-cycle pulse on a timed-out access.
REQ-012 MisalignErr  output  1  one-cycle pulse on a misaligned access (macro only).
REQ-013 mem_req / mem_we  output  1 each  bus request and write strobe.
REQ-014 mem_addr  output  32  word-aligned address, Addr with bits [1:0] forced to 00.
REQ-015 mem_wdata / mem_be  output  32 / 4  lane-replicated store data and byte enables.
REQ-016 mem_gnt / mem_rvalid  input  1 each  request accepted / read data valid.
REQ-017 mem_rdata  input  32  read data, sampled only when mem_rvalid is high.

Function
REQ-018 The FSM SHALL have the states IDLE, REQ, WAIT and DONE.
REQ-019 IDLE: on (MemRead|MemWrite), Stall SHALL go high combinationally and the FSM SHALL move to REQ; MemWrite SHALL take priority when both are high.
REQ-020 REQ: mem_req=1, and mem_addr/mem_we/mem_be/mem_wdata SHALL be registered at IDLE exit and held stable until mem_gnt; on gnt a write SHALL go to DONE and a read SHALL go to WAIT.
REQ-021 WAIT: on mem_rvalid, the formatted data SHALL be registered into ReadData and the FSM SHALL go to DONE; mem_rvalid SHALL be ignored outside WAIT.
REQ-022 DONE: Stall=0 for exactly one cycle, then the FSM SHALL return to IDLE unconditionally; requests seen in DONE SHALL be ignored.
REQ-023 Minimum load latency with gnt in the first REQ cycle and rvalid in the first WAIT cycle SHALL be Stall high for 3 cycles and ReadData valid in DONE.
REQ-024 Loads SHALL select the byte via Addr[1:0] and the halfword via Addr[1], sign-extending for B/H and zero-extending for BU/HU.
REQ-025 Stores: SB be=0001<<Addr[1:0] with the byte replicated x4; SH be=0011 or 1100 with the half replicated x2; SW be=1111.
REQ-026 A cycle counter SHALL clear on IDLE exit; on reaching TIMEOUT in REQ or WAIT, the FSM SHALL go to DONE with ReadData=0 and BusErr pulsed during DONE.
REQ-027 ReadData SHALL hold its last value except on a load capture or an abort.

Reset
REQ-028 On reset, the FSM SHALL go to IDLE, with ReadData=0, counter=0, and Stall, mem_req, mem_we, BusErr and MisalignErr all 0, and mem_be=0000.
REQ-029 Reset asserted mid-access SHALL abandon the transaction immediately; a later mem_rvalid SHALL be ignored.

Configuration
REQ-030 With DMEM_MISALIGN_TRAP_EN defined: H/HU/SH at odd Addr, or W/SW with Addr[1:0]!=00, SHALL issue no bus request, go IDLE->DONE (Stall high for 1 cycle), set ReadData=0 for loads, and pulse MisalignErr in DONE.
REQ-031 Without DMEM_MISALIGN_TRAP_EN: Addr[0] SHALL be ignored for halfwords, Addr[1:0] SHALL be ignored for words, and MisalignErr SHALL be tied to 0.

Structure
REQ-032 Package dmem_pkg SHALL hold the Funct3 size constants and the FSM state encoding.
REQ-033 Load formatting SHALL be a sub-module named load_align (combinational, mem_rdata+Addr[1:0]+Funct3 -> 32-bit result).

Verification
REQ-034 LW at 0x100, gnt in cycle 1, rvalid in cycle 2 with 0xDEADBEEF -> Stall high for 3 cycles, then ReadData=0xDEADBEEF.
REQ-035 LB at 0x103 with rdata 0x80FF0000 -> ReadData=0xFFFFFF80; LBU at the same address -> 0x00000080.
REQ-036 SH at 0x102 with StoreData 0x0000ABCD -> mem_be=1100, mem_wdata=0xABCDABCD, mem_addr=0x100.
REQ-037 LW with gnt withheld for TIMEOUT cycles -> BusErr pulses once, ReadData=0, FSM returns to IDLE.
REQ-038 Reset asserted in WAIT, then rvalid -> ReadData stays 0 and no Stall.
REQ-039 With macro: LW at 0x102 -> mem_req never asserted, MisalignErr pulses once; without macro: word read from 0x100.
